alu_issue_queue: RTL and testbench

Operand issue and result capture stage wrapped around the combinational `four_bit_ALU`. It buffers incoming operations (A, B, Sel) in a small FIFO and presents them one at a time on registered operand outputs that drive the ALU. It captures the ALU's response one cycle later and holds the selected result, with its comparison flags, behind a valid/ready output handshake. It sits between the instruction/operand source and any result consumer. The ALU itself stays purely combinational.

---
 rtl/alu_issue_queue.sv | 155 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Issue/capture stage around a combinational 4-bit ALU: operations queue in a
// small FIFO, issue one at a time on registered operands, and results are held for a handshake.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_A,
  input  logic [3:0]             in_B,
  input  logic [1:0]             in_Sel,
  output logic [3:0]             alu_A,
  output logic [3:0]             alu_B,
  output logic [1:0]             alu_Sel,
  input  logic [4:0]             alu_Y_addSub,
  input  logic [3:0]             alu_Y_and,
  input  logic                   alu_Eq,
  input  logic                   alu_Gt,
  input  logic                   alu_Lt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_R,
  output logic [1:0]             out_Sel,
  output logic [2:0]             out_flags,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_pop;
  logic            w_capture;
  logic            w_push;
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [9:0]      w_head;
  logic [3:0]      r_alu_a_p0;
  logic [3:0]      r_alu_b_p0;
  logic [1:0]      r_alu_sel_p0;
  logic [4:0]      r_out_r_p1;
  logic [1:0]      r_out_sel_p1;
  logic [2:0]      r_out_flags_p1;

  function automatic logic [4:0] f_select(input logic [1:0] sel,
                                          input logic [4:0] addsub,
                                          input logic [3:0] and_y,
                                          input logic eq, input logic gt, input logic lt);
    logic [4:0] r;
    case (sel)
      2'b10:   r = {1'b0, and_y};
      2'b11:   r = {2'b00, eq, gt, lt};
      default: r = addsub;
    endcase
    return r;
  endfunction

  assign in_ready = (r_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  // FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_A, in_B, in_Sel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture    = 1'b1;
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = S_EXEC;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Stage p0: operand registers driving the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a_p0   <= '0;
      r_alu_b_p0   <= '0;
      r_alu_sel_p0 <= '0;
    end else if (w_pop) begin
      r_alu_a_p0   <= w_head[9:6];
      r_alu_b_p0   <= w_head[5:2];
      r_alu_sel_p0 <= w_head[1:0];
    end
  end

  // Stage p1: captured result held until the consumer accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_r_p1     <= '0;
      r_out_sel_p1   <= '0;
      r_out_flags_p1 <= '0;
    end else if (w_capture) begin
      r_out_r_p1     <= f_select(r_alu_sel_p0, alu_Y_addSub, alu_Y_and, alu_Eq, alu_Gt, alu_Lt);
      r_out_sel_p1   <= r_alu_sel_p0;
      r_out_flags_p1 <= {alu_Eq, alu_Gt, alu_Lt};
    end
  end

  assign alu_A     = r_alu_a_p0;
  assign alu_B     = r_alu_b_p0;
  assign alu_Sel   = r_alu_sel_p0;
  assign out_valid = (r_state == S_HOLD);
  assign out_R     = r_out_r_p1;
  assign out_Sel   = r_out_sel_p1;
  assign out_flags = r_out_flags_p1;
  assign count     = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a behavioural ALU drives the DUT's ALU inputs,
// expected results are queued on acceptance and checked by an independent monitor.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0] r;
    logic [1:0] s;
    logic [2:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_A, in_B, alu_A, alu_B, alu_Y_and;
  logic [1:0] in_Sel, alu_Sel, out_Sel;
  logic [4:0] alu_Y_addSub, out_R;
  logic       alu_Eq, alu_Gt, alu_Lt;
  logic [2:0] out_flags;
  logic [$clog2(DEPTH):0] count;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   track_max = 0;
  int   max_cnt = 0;
  bit   done_rand;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational ALU fed by the DUT's registered operands
  assign alu_Y_addSub = (alu_Sel == 2'b01) ? ({1'b0, alu_A} - {1'b0, alu_B})
                                           : ({1'b0, alu_A} + {1'b0, alu_B});
  assign alu_Y_and = alu_A & alu_B;
  assign alu_Eq    = (alu_A == alu_B);
  assign alu_Gt    = (alu_A > alu_B);
  assign alu_Lt    = (alu_A < alu_B);

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_Sel(in_Sel),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Sel(alu_Sel),
    .alu_Y_addSub(alu_Y_addSub), .alu_Y_and(alu_Y_and),
    .alu_Eq(alu_Eq), .alu_Gt(alu_Gt), .alu_Lt(alu_Lt),
    .out_valid(out_valid), .out_ready(out_ready), .out_R(out_R),
    .out_Sel(out_Sel), .out_flags(out_flags), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int s);
    exp_t e;
    int   r;
    e.f = {a == b, a > b, a < b};
    case (s)
      0:       r = (a + b) % 32;
      1:       r = (a - b + 32) % 32;
      2:       r = a & b;
      default: r = (a == b) * 4 + (a > b) * 2 + (a < b);
    endcase
    e.r = r[4:0];
    e.s = s[1:0];
    return e;
  endfunction

  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                       input int maxw, output bit acc);
    int n = 0;
    in_A = a; in_B = b; in_Sel = s; in_valid = 1'b1;
    acc = 1'b0;
    while (n < maxw) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(model(a, b, s));
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    bit acc;
    offer(a, b, s, 200, acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every held result must match the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_vs_count", in_ready, (count < DEPTH));
      if (track_max && int'(count) > max_cnt) max_cnt = int'(count);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("out_R", out_R, exp_q[0].r);
          chk("out_Sel", out_Sel, exp_q[0].s);
          chk("out_flags", out_flags, exp_q[0].f);
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    int nacc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_A = '0; in_B = '0; in_Sel = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_alu_ops", {alu_A, alu_B, alu_Sel}, 0);
    chk("rst_out_regs", {out_R, out_Sel, out_flags}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Add with latency check
    out_ready = 1'b1;
    send(4'b1001, 4'b1000, 2'b00);
    chk("lat_e0_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1_valid", out_valid, 0);
    chk("lat_e1_alu_A", alu_A, 4'b1001);
    @(posedge clk); #1;
    chk("lat_e2_valid", out_valid, 1);
    chk("add_R", out_R, 5'b10001);
    drain();

    // Sub then AND back-to-back
    hs_cyc.delete();
    send(4'b0011, 4'b0101, 2'b01);
    send(4'b1100, 4'b1010, 2'b10);
    drain();
    chk("b2b_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) chk("b2b_spacing", hs_cyc[1] - hs_cyc[0], 2);

    // Compare
    send(4'b0111, 4'b0111, 2'b11);
    send(4'b1111, 4'b0001, 2'b11);
    drain();

    // Backpressure / full
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 7; i++) begin
      offer(4'($urandom), 4'($urandom), 2'($urandom), 8, acc);
      if (acc) nacc++;
    end
    chk("bp_accepted", nacc, DEPTH + 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_count", count, DEPTH);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();
    chk("bp_count_after", count, 0);

    // Paced stream: simultaneous push/pop, pointer wrap
    track_max = 1; max_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom), 4'($urandom), 2'($urandom));
      @(posedge clk); #1;
    end
    drain();
    track_max = 0;
    chk("stream_max_count", (max_cnt <= 1), 1);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'($urandom), 4'($urandom), 2'($urandom));
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_alu_A", alu_A, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(4'b0001, 4'b0001, 2'b00);
    repeat (2) @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_R", out_R, 5'b00010);
    drain();

    // Randomized traffic with random backpressure
    done_rand = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(4'($urandom), 4'($urandom), 2'($urandom));
        end
        done_rand = 1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_count", count, 0);
    chk("final_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
